// File: rtl/dmem_port_arbiter_if.sv
// Request/response and memory-side signal bundle for dmem_port_arbiter.
// slave: arbiter side; master: requesters plus the memory.
interface dmem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  p0_req_valid;
  logic                  p0_req_ready;
  logic                  p0_req_we;
  logic [ADDR_WIDTH-1:0] p0_req_addr;
  logic [DATA_WIDTH-1:0] p0_req_wdata;
  logic [3:0]            p0_req_be;
  logic                  p0_rsp_valid;
  logic [DATA_WIDTH-1:0] p0_rsp_rdata;

  logic                  p1_req_valid;
  logic                  p1_req_ready;
  logic                  p1_req_we;
  logic [ADDR_WIDTH-1:0] p1_req_addr;
  logic [DATA_WIDTH-1:0] p1_req_wdata;
  logic [3:0]            p1_req_be;
  logic                  p1_rsp_valid;
  logic [DATA_WIDTH-1:0] p1_rsp_rdata;

  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata, p0_req_be,
    output p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
    input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata, p1_req_be,
    output p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
    output mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata, p0_req_be,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
    output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata, p1_req_be,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
    input  mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data memory; partial stores use read-modify-write.
// DMEM_ARB_RR_EN selects round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic                clk,
  input logic                rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StMergeWr} state_e;

  state_e                state_q, state_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;
  logic [ADDR_WIDTH-1:0] merge_addr_q, merge_addr_d;
  logic [DATA_WIDTH-1:0] merge_data_q, merge_data_d;
  logic                  owner_q, owner_d;

  logic                  any_valid, tie_gnt1, gnt1, accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata, merged;
  logic [3:0]            sel_be;
  logic                  mem_write_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Resets to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt1;
    end
  end

  assign tie_gnt1 = ~last_q;
`else
  assign tie_gnt1 = 1'b0;
`endif

  assign any_valid = bus.p0_req_valid | bus.p1_req_valid;
  assign gnt1      = (bus.p0_req_valid && bus.p1_req_valid) ? tie_gnt1 : bus.p1_req_valid;
  assign accept    = (state_q == StIdle) && any_valid;

  assign sel_we    = gnt1 ? bus.p1_req_we    : bus.p0_req_we;
  assign sel_addr  = gnt1 ? bus.p1_req_addr  : bus.p0_req_addr;
  assign sel_wdata = gnt1 ? bus.p1_req_wdata : bus.p0_req_wdata;
  assign sel_be    = gnt1 ? bus.p1_req_be    : bus.p0_req_be;

  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      merged[8*i +: 8] = sel_be[i] ? sel_wdata[8*i +: 8] : bus.mem_rdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    merge_addr_d = merge_addr_q;
    merge_data_d = merge_data_q;
    owner_d      = owner_q;
    mem_write_c  = 1'b0;
    mem_addr_c   = sel_addr;
    mem_wdata_c  = sel_wdata;

    case (state_q)
      StIdle: begin
        if (any_valid) begin
          if (!sel_we) begin
            rsp0_valid_d = ~gnt1;
            rsp1_valid_d = gnt1;
            if (gnt1) rsp1_rdata_d = bus.mem_rdata;
            else      rsp0_rdata_d = bus.mem_rdata;
          end else if (sel_be == 4'hF) begin
            mem_write_c  = 1'b1;
            rsp0_valid_d = ~gnt1;
            rsp1_valid_d = gnt1;
          end else if (sel_be == 4'h0) begin
            rsp0_valid_d = ~gnt1;
            rsp1_valid_d = gnt1;
          end else begin
            merge_addr_d = sel_addr;
            merge_data_d = merged;
            owner_d      = gnt1;
            state_d      = StMergeWr;
          end
        end
      end
      StMergeWr: begin
        mem_write_c  = 1'b1;
        mem_addr_c   = merge_addr_q;
        mem_wdata_c  = merge_data_q;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      merge_addr_q <= '0;
      merge_data_q <= '0;
      owner_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      merge_addr_q <= merge_addr_d;
      merge_data_q <= merge_data_d;
      owner_q      <= owner_d;
    end
  end

  assign bus.p0_req_ready = accept && !gnt1;
  assign bus.p1_req_ready = accept && gnt1;
  assign bus.p0_rsp_valid = rsp0_valid_q;
  assign bus.p1_rsp_valid = rsp1_valid_q;
  assign bus.p0_rsp_rdata = rsp0_rdata_q;
  assign bus.p1_rsp_rdata = rsp1_rdata_q;
  // Gated so a write in flight cannot land while reset is asserted.
  assign bus.mem_write    = mem_write_c & rst_n;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_wdata    = mem_wdata_c;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural memory model.
module tb_dmem_port_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   n_writes;

  logic [31:0] mem [1024];

  dmem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

  dmem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      n_writes <= n_writes + 1;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_p0(input logic v, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    bus.p0_req_valid = v;
    bus.p0_req_we    = we;
    bus.p0_req_addr  = a;
    bus.p0_req_wdata = d;
    bus.p0_req_be    = be;
  endtask

  task automatic set_p1(input logic v, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    bus.p1_req_valid = v;
    bus.p1_req_we    = we;
    bus.p1_req_addr  = a;
    bus.p1_req_wdata = d;
    bus.p1_req_be    = be;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    set_p0(1'b1, 1'b1, a, d, 4'hF);
    tick();
    set_p0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
  endtask

  logic        exp_g1 [4];
  int unsigned w_before;

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    n_writes = 0;
    rst_n    = 1'b0;
    set_p0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    set_p1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
`ifdef DMEM_ARB_RR_EN
    exp_g1 = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g1 = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state
    tick();
    tick();
    chk1("rst_p0_rsp_valid", bus.p0_rsp_valid, 1'b0);
    chk1("rst_p1_rsp_valid", bus.p1_rsp_valid, 1'b0);
    chk32("rst_p0_rdata", bus.p0_rsp_rdata, 32'h0);
    chk32("rst_p1_rdata", bus.p1_rsp_rdata, 32'h0);
    chk1("rst_mem_write", bus.mem_write, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk1("idle_p0_ready", bus.p0_req_ready, 1'b0);
    chk32("idle_mem_addr", 32'(bus.mem_addr), 32'h0);

    // Full store then load at 0x004
    set_p0(1'b1, 1'b1, 10'h004, 32'hDEADBEEF, 4'hF);
    #1;
    chk1("fst_ready", bus.p0_req_ready, 1'b1);
    chk1("fst_mem_write", bus.mem_write, 1'b1);
    chk32("fst_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    tick();
    set_p0(1'b1, 1'b0, 10'h004, 32'h0, 4'h0);
    #1;
    chk1("fst_rsp", bus.p0_rsp_valid, 1'b1);
    chk32("fst_mem", mem[4], 32'hDEADBEEF);
    chk1("ld_ready", bus.p0_req_ready, 1'b1);
    tick();
    set_p0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    chk1("ld_p0_rsp", bus.p0_rsp_valid, 1'b1);
    chk32("ld_p0_rdata", bus.p0_rsp_rdata, 32'hDEADBEEF);
    chk1("ld_p1_rsp", bus.p1_rsp_valid, 1'b0);
    tick();
    chk1("ld_pulse_end", bus.p0_rsp_valid, 1'b0);

    preload(10'h010, 32'h11223344);
    preload(10'h020, 32'hCAFEF00D);
    preload(10'h030, 32'h55667788);

    // Partial store from p1 with p0 contending during the merge cycle
    set_p1(1'b1, 1'b1, 10'h010, 32'hAABBCCDD, 4'b0101);
    #1;
    chk1("pst_p1_ready", bus.p1_req_ready, 1'b1);
    chk1("pst_T_no_write", bus.mem_write, 1'b0);
    tick();
    set_p1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    set_p0(1'b1, 1'b0, 10'h004, 32'h0, 4'h0);
    #1;
    chk1("pst_T1_write", bus.mem_write, 1'b1);
    chk32("pst_T1_addr", 32'(bus.mem_addr), 32'h010);
    chk32("pst_T1_wdata", bus.mem_wdata, 32'h11BB33DD);
    chk1("pst_T1_p0_ready", bus.p0_req_ready, 1'b0);
    chk1("pst_T1_no_rsp", bus.p1_rsp_valid, 1'b0);
    tick();
    chk1("pst_T2_rsp", bus.p1_rsp_valid, 1'b1);
    chk32("pst_mem", mem[16], 32'h11BB33DD);
    chk1("pst_T2_p0_ready", bus.p0_req_ready, 1'b1);
    tick();
    set_p0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    chk1("pst_T3_p0_rsp", bus.p0_rsp_valid, 1'b1);
    chk1("pst_T3_p1_rsp", bus.p1_rsp_valid, 1'b0);

    // p1 load; also leaves port 1 as the last grant
    set_p1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    tick();
    set_p1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    chk1("p1ld_rsp", bus.p1_rsp_valid, 1'b1);
    chk32("p1ld_rdata", bus.p1_rsp_rdata, 32'hCAFEF00D);

    // Both ports hold valid loads for four cycles
    set_p0(1'b1, 1'b0, 10'h004, 32'h0, 4'h0);
    set_p1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("arb_p0_ready", bus.p0_req_ready, ~exp_g1[i]);
      chk1("arb_p1_ready", bus.p1_req_ready, exp_g1[i]);
      tick();
      chk1("arb_p0_rsp", bus.p0_rsp_valid, ~exp_g1[i]);
      chk1("arb_p1_rsp", bus.p1_rsp_valid, exp_g1[i]);
      chk32("arb_rdata", exp_g1[i] ? bus.p1_rsp_rdata : bus.p0_rsp_rdata,
            exp_g1[i] ? 32'hCAFEF00D : 32'hDEADBEEF);
    end
    set_p0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    #1;
    chk1("arb_p1_after_drop", bus.p1_req_ready, 1'b1);
    tick();
    set_p1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    chk1("arb_p1_rsp_after_drop", bus.p1_rsp_valid, 1'b1);
    tick();

    // Empty-mask store is a no-op with a response
    w_before = n_writes;
    set_p0(1'b1, 1'b1, 10'h020, 32'h12345678, 4'h0);
    #1;
    chk1("be0_ready", bus.p0_req_ready, 1'b1);
    chk1("be0_no_write", bus.mem_write, 1'b0);
    tick();
    set_p0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    chk1("be0_rsp", bus.p0_rsp_valid, 1'b1);
    chk32("be0_mem", mem[32], 32'hCAFEF00D);
    chk32("be0_write_count", n_writes, w_before);
    tick();

    // Reset during the merge cycle drops the write
    set_p1(1'b1, 1'b1, 10'h030, 32'h0, 4'b0011);
    tick();
    set_p1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    #1;
    chk1("rmw_merge_write", bus.mem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rmw_rst_write_gated", bus.mem_write, 1'b0);
    tick();
    chk32("rmw_rst_mem", mem[48], 32'h55667788);
    chk1("rmw_rst_p1_rsp", bus.p1_rsp_valid, 1'b0);
    chk32("rmw_rst_p1_rdata", bus.p1_rsp_rdata, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk1("rmw_post_p0_rsp", bus.p0_rsp_valid, 1'b0);
    chk1("rmw_post_p1_rsp", bus.p1_rsp_valid, 1'b0);
    chk1("rmw_post_write", bus.mem_write, 1'b0);
    chk32("rmw_post_mem", mem[48], 32'h55667788);
    set_p0(1'b1, 1'b0, 10'h030, 32'h0, 4'h0);
    #1;
    chk1("rmw_post_idle_ready", bus.p0_req_ready, 1'b1);
    tick();
    set_p0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    chk1("rmw_post_ld_rsp", bus.p0_rsp_valid, 1'b1);
    chk32("rmw_post_ld_rdata", bus.p0_rsp_rdata, 32'h55667788);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
